// File: rtl/mc_request_arbiter.sv
// Round-robin arbiter sharing the memory_controller request port between NUM_REQ clients, with in-order ID tracking for completions.
// Latency: grant is combinational; the request reaches the controller 1 cycle after transfer; a response pulse comes 1 cycle after read_done/write_done.
// Backpressure: no grant while out_busy is high, while draining, or while the ID FIFO for that request type is full.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/type/address/data    per-requester request fields (address/data flattened, requester i at [i*W +: W])
//   req_ready                      one-hot combinational grant
//   rsp_read_valid, rsp_data       one-hot read-return pulse and its data
//   rsp_write_valid                one-hot write-complete pulse
//   drain_req, drained             quiesce handshake
//   err_unexpected                 sticky: completion seen with nothing outstanding
//   in_valid, in_request_*         issue port to memory_controller
//   out_busy, write_done,
//   read_done, data_out            status/return from memory_controller
//   stat_grants                    per-requester 16-bit saturating grant counters (only with MC_ARB_STATS_EN)
//
// Optional: define MC_ARB_STATS_EN to add the stat_grants output and its counters.

// Generic synchronous FIFO used for the outstanding-ID queues.
// Latency: pop_dat shows the head combinationally; a push is visible on the next cycle.
// Backpressure: pushes while full and pops while empty are ignored; the caller watches full/empty.
module mc_arb_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit tells full apart from empty when the index bits match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_vld && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_vld && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_vld && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

module mc_request_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int data_width      = 16,
    parameter int address_width   = 30,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_type,
    input  logic [NUM_REQ*address_width-1:0] req_address,
    input  logic [NUM_REQ*data_width-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_read_valid,
    output logic [NUM_REQ-1:0]               rsp_write_valid,
    output logic [data_width-1:0]            rsp_data,
    input  logic                             drain_req,
    output logic                             drained,
    output logic                             err_unexpected,
    output logic                             in_valid,
    output logic                             in_request_type,
    output logic [address_width-1:0]         in_request_address,
    output logic [data_width-1:0]            in_request_data,
    input  logic                             out_busy,
    input  logic                             write_done,
    input  logic                             read_done,
    input  logic [data_width-1:0]            data_out
`ifdef MC_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]            stat_grants
`endif
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DRAINED
    } state_t;

    state_t                   state;
    logic [IDW-1:0]           rr_ptr;
    logic [NUM_REQ-1:0]       elig;
    logic [NUM_REQ-1:0]       grant;
    logic                     xfer;
    logic [IDW-1:0]           gnt_idx;
    logic                     sel_type;
    logic [address_width-1:0] sel_addr;
    logic [data_width-1:0]    sel_data;
    logic                     rd_push;
    logic                     wr_push;
    logic                     rd_pop;
    logic                     wr_pop;
    logic                     rd_full;
    logic                     rd_empty;
    logic                     wr_full;
    logic                     wr_empty;
    logic [IDW-1:0]           rd_head;
    logic [IDW-1:0]           wr_head;

    // First set bit of el, searching upward from p+1 with wrap-around.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] el,
                                                   input logic [IDW-1:0]     p);
        logic [NUM_REQ-1:0] g;
        logic               found;
        int                 idx;
        g     = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(p) + k) % NUM_REQ;
            if (!found && el[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [NUM_REQ-1:0] id_onehot(input logic [IDW-1:0] id);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            oh[i] = (id == IDW'(i));
        end
        return oh;
    endfunction

    // The full check uses the registered FIFO state only, so a pop in the
    // same cycle never opens a slot for that cycle's grant.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i] && (state == ST_RUN) && !out_busy &&
                      !(req_type[i] ? wr_full : rd_full);
        end
    end

    assign grant     = rr_pick(elig, rr_ptr);
    assign req_ready = grant;
    assign xfer      = |grant;

    always_comb begin
        gnt_idx  = '0;
        sel_type = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx  = IDW'(i);
                sel_type = req_type[i];
                sel_addr = req_address[i*address_width +: address_width];
                sel_data = req_data[i*data_width +: data_width];
            end
        end
    end

    assign rd_push = xfer && !sel_type;
    assign wr_push = xfer && sel_type;
    assign rd_pop  = read_done && !rd_empty;
    assign wr_pop  = write_done && !wr_empty;

    mc_arb_id_fifo #(.WIDTH(IDW), .DEPTH(MAX_OUTSTANDING)) u_rd_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (rd_push),
        .push_dat (gnt_idx),
        .pop_vld  (rd_pop),
        .pop_dat  (rd_head),
        .full     (rd_full),
        .empty    (rd_empty)
    );

    mc_arb_id_fifo #(.WIDTH(IDW), .DEPTH(MAX_OUTSTANDING)) u_wr_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (wr_push),
        .push_dat (gnt_idx),
        .pop_vld  (wr_pop),
        .pop_dat  (wr_head),
        .full     (wr_full),
        .empty    (wr_empty)
    );

    // Issue register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr             <= IDW'(NUM_REQ - 1);
            in_valid           <= 1'b0;
            in_request_type    <= 1'b0;
            in_request_address <= '0;
            in_request_data    <= '0;
        end else begin
            in_valid <= xfer;
            if (xfer) begin
                rr_ptr             <= gnt_idx;
                in_request_type    <= sel_type;
                in_request_address <= sel_addr;
                in_request_data    <= sel_data;
            end
        end
    end

    // Completion routing; a completion with nothing outstanding is flagged, not popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_read_valid  <= '0;
            rsp_write_valid <= '0;
            rsp_data        <= '0;
            err_unexpected  <= 1'b0;
        end else begin
            rsp_read_valid  <= rd_pop ? id_onehot(rd_head) : '0;
            rsp_write_valid <= wr_pop ? id_onehot(wr_head) : '0;
            if (rd_pop) begin
                rsp_data <= data_out;
            end
            if ((read_done && rd_empty) || (write_done && wr_empty)) begin
                err_unexpected <= 1'b1;
            end
        end
    end

    // Drain FSM. Grants are gated on the registered state, so a grant in
    // the cycle drain_req rises still goes through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            drained <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (drain_req) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!drain_req) begin
                        state <= ST_RUN;
                    end else if (rd_empty && wr_empty && !in_valid) begin
                        state   <= ST_DRAINED;
                        drained <= 1'b1;
                    end
                end
                ST_DRAINED: begin
                    if (!drain_req) begin
                        state   <= ST_RUN;
                        drained <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_RUN;
                    drained <= 1'b0;
                end
            endcase
        end
    end

`ifdef MC_ARB_STATS_EN
    logic [15:0] stat_cnt [NUM_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && (stat_cnt[i] != 16'hFFFF)) begin
                    stat_cnt[i] <= stat_cnt[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_grants[g*16 +: 16] = stat_cnt[g];
    end
`endif
endmodule

// File: tb/tb_mc_request_arbiter.sv
module tb_mc_request_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 30;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_type = '0;
    logic [N*AW-1:0] req_address;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_read_valid;
    logic [N-1:0]    rsp_write_valid;
    logic [DW-1:0]   rsp_data;
    logic            drain_req = 1'b0;
    logic            drained;
    logic            err_unexpected;
    logic            in_valid;
    logic            in_request_type;
    logic [AW-1:0]   in_request_address;
    logic [DW-1:0]   in_request_data;
    logic            out_busy = 1'b0;
    logic            write_done = 1'b0;
    logic            read_done = 1'b0;
    logic [DW-1:0]   data_out = '0;
`ifdef MC_ARB_STATS_EN
    logic [N*16-1:0] stat_grants;
`endif

    always #5 clk = ~clk;

    mc_request_arbiter dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_valid          (req_valid),
        .req_type           (req_type),
        .req_address        (req_address),
        .req_data           (req_data),
        .req_ready          (req_ready),
        .rsp_read_valid     (rsp_read_valid),
        .rsp_write_valid    (rsp_write_valid),
        .rsp_data           (rsp_data),
        .drain_req          (drain_req),
        .drained            (drained),
        .err_unexpected     (err_unexpected),
        .in_valid           (in_valid),
        .in_request_type    (in_request_type),
        .in_request_address (in_request_address),
        .in_request_data    (in_request_data),
        .out_busy           (out_busy),
        .write_done         (write_done),
        .read_done          (read_done),
        .data_out           (data_out)
`ifdef MC_ARB_STATS_EN
        ,
        .stat_grants        (stat_grants)
`endif
    );

    // One record per cycle: inputs for the cycle, the expected combinational
    // grant, and the registered outputs expected during that cycle.
    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  typ;
        logic        busy;
        logic        rd;
        logic        wr;
        logic        drn;
        logic [15:0] dout;
        logic [3:0]  e_rdy;
        logic        e_iv;
        logic [1:0]  e_src;
        logic        e_ityp;
        logic [3:0]  e_rr;
        logic [3:0]  e_rw;
        logic [15:0] e_rdat;
        logic        e_drn;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   part1_end;

    function automatic logic [AW-1:0] addr_of(input int i);
        return (i == 0) ? 30'd2 : 30'(i * 256);
    endfunction

    function automatic logic [DW-1:0] data_of(input int i);
        return (i == 0) ? 16'd10 : 16'(i * 16'h1111);
    endfunction

    function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] typ,
                                input logic busy, input logic rd, input logic wr,
                                input logic drn, input logic [15:0] dout,
                                input logic [3:0] e_rdy, input logic e_iv,
                                input logic [1:0] e_src, input logic e_ityp,
                                input logic [3:0] e_rr, input logic [3:0] e_rw,
                                input logic [15:0] e_rdat, input logic e_drn,
                                input logic e_err);
        vec_t v;
        v.vld = vld;   v.typ = typ;   v.busy = busy;   v.rd = rd;
        v.wr = wr;     v.drn = drn;   v.dout = dout;   v.e_rdy = e_rdy;
        v.e_iv = e_iv; v.e_src = e_src; v.e_ityp = e_ityp; v.e_rr = e_rr;
        v.e_rw = e_rw; v.e_rdat = e_rdat; v.e_drn = e_drn; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        v = vecs[k];
        @(posedge clk);
        #1;
        req_valid  = v.vld;
        req_type   = v.typ;
        out_busy   = v.busy;
        read_done  = v.rd;
        write_done = v.wr;
        drain_req  = v.drn;
        data_out   = v.dout;
        #6;
        chk($sformatf("v%0d_ready", k), 32'(req_ready), 32'(v.e_rdy));
        chk($sformatf("v%0d_in_valid", k), 32'(in_valid), 32'(v.e_iv));
        if (v.e_iv) begin
            chk($sformatf("v%0d_in_type", k), 32'(in_request_type), 32'(v.e_ityp));
            chk($sformatf("v%0d_in_addr", k), 32'(in_request_address), 32'(addr_of(int'(v.e_src))));
            if (v.e_ityp) begin
                chk($sformatf("v%0d_in_data", k), 32'(in_request_data), 32'(data_of(int'(v.e_src))));
            end
        end
        chk($sformatf("v%0d_rsp_rd", k), 32'(rsp_read_valid), 32'(v.e_rr));
        if (v.e_rr != 4'b0000) begin
            chk($sformatf("v%0d_rsp_data", k), 32'(rsp_data), 32'(v.e_rdat));
        end
        chk($sformatf("v%0d_rsp_wr", k), 32'(rsp_write_valid), 32'(v.e_rw));
        chk($sformatf("v%0d_drained", k), 32'(drained), 32'(v.e_drn));
        chk($sformatf("v%0d_err", k), 32'(err_unexpected), 32'(v.e_err));
    endtask

    task automatic idle_inputs();
        req_valid  = '0;
        req_type   = '0;
        out_busy   = 1'b0;
        read_done  = 1'b0;
        write_done = 1'b0;
        drain_req  = 1'b0;
        data_out   = '0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            req_address[i*AW +: AW] = addr_of(i);
            req_data[i*DW +: DW]    = data_of(i);
        end

        // Single write then read from requester 0 (pointer starts at 3).
        vecs.push_back(mk(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  4'b0001, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b0));
        vecs.push_back(mk(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  4'b0001, 1'b1, 2'd0, 1'b1, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0,  4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'd10, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0001, 16'h0,  1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  4'b0000, 1'b0, 2'd0, 1'b0, 4'b0001, 4'b0000, 16'd10, 1'b0, 1'b0));
        // Fairness: all four hold reads; pointer is 0 so order is 1,2,3,0,1.
        vecs.push_back(mk(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  4'b0010, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  4'b0100, 1'b1, 2'd1, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'hA1, 4'b1000, 1'b1, 2'd2, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'hA2, 4'b0001, 1'b1, 2'd3, 1'b0, 4'b0010, 4'b0000, 16'hA1, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'hA3, 4'b0010, 1'b1, 2'd0, 1'b0, 4'b0100, 4'b0000, 16'hA2, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'hA4, 4'b0000, 1'b1, 2'd1, 1'b0, 4'b1000, 4'b0000, 16'hA3, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'hA5, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0001, 4'b0000, 16'hA4, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  4'b0000, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000, 16'hA5, 1'b0, 1'b0));
        // Backpressure: out_busy for 5 cycles with requester 2 waiting.
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 16'h0, 1'b0, 1'b0));
        end
        vecs.push_back(mk(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  4'b0100, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  4'b0000, 1'b1, 2'd2, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h55, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  4'b0000, 1'b0, 2'd0, 1'b0, 4'b0100, 4'b0000, 16'h55, 1'b0, 1'b0));
        // Read FIFO fills with 8 reads from requester 1.
        vecs.push_back(mk(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  4'b0010, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b0));
        for (int i = 0; i < 7; i++) begin
            vecs.push_back(mk(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 4'b0010, 1'b1, 2'd1, 1'b0, 4'b0000, 4'b0000, 16'h0, 1'b0, 1'b0));
        end
        // 9th read blocked, write from requester 0 still granted.
        vecs.push_back(mk(4'b0011, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  4'b0001, 1'b1, 2'd1, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b0));
        // Pop in the same cycle does not unblock; the next cycle does.
        vecs.push_back(mk(4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h77, 4'b0000, 1'b1, 2'd0, 1'b1, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b0));
        vecs.push_back(mk(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  4'b0010, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000, 16'h77, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0,  4'b0000, 1'b1, 2'd1, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b0));
        part1_end = vecs.size();
        // After a reset (pointer back to 3): reads from 3 then 1, write from 0.
        vecs.push_back(mk(4'b1001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  4'b0001, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b0));
        vecs.push_back(mk(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  4'b1000, 1'b1, 2'd0, 1'b1, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b0));
        vecs.push_back(mk(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  4'b0010, 1'b1, 2'd3, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'hC3, 4'b0000, 1'b1, 2'd1, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'hC1, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b1000, 4'b0001, 16'hC3, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  4'b0000, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000, 16'hC1, 1'b0, 1'b0));
        // Drain: two reads outstanding, a third granted in the cycle drain_req rises.
        vecs.push_back(mk(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  4'b0001, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b0));
        vecs.push_back(mk(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  4'b0100, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b0));
        vecs.push_back(mk(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0,  4'b0010, 1'b1, 2'd2, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0,  4'b0000, 1'b1, 2'd1, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b0));
        vecs.push_back(mk(4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'hD0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b0));
        vecs.push_back(mk(4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'hD2, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0001, 4'b0000, 16'hD0, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'hD1, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0100, 4'b0000, 16'hD2, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0,  4'b0000, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000, 16'hD1, 1'b0, 1'b0));
        // Drained; an extra read_done raises the error with no pulse.
        vecs.push_back(mk(4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0,  4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b1, 1'b0));
        vecs.push_back(mk(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b1, 1'b1));
        // Back in RUN: requester 3 granted (pointer 1), error stays sticky.
        vecs.push_back(mk(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  4'b1000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b1));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  4'b0000, 1'b1, 2'd3, 1'b0, 4'b0000, 4'b0000, 16'h0,  1'b0, 1'b1));

        // Reset state.
        #8;
        chk("rst_in_valid", 32'(in_valid), 32'd0);
        chk("rst_in_addr", 32'(in_request_address), 32'd0);
        chk("rst_rsp_rd", 32'(rsp_read_valid), 32'd0);
        chk("rst_rsp_wr", 32'(rsp_write_valid), 32'd0);
        chk("rst_drained", 32'(drained), 32'd0);
        chk("rst_err", 32'(err_unexpected), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < part1_end; k++) begin
            run_vec(k);
        end

        // Reset with 8 reads outstanding: the write pulse is killed and the
        // discarded read IDs never produce a response.
        @(posedge clk);
        #1 idle_inputs();
        #1 chk("pre_rst_rsp_wr", 32'(rsp_write_valid), 32'b0001);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_wr", 32'(rsp_write_valid), 32'd0);
        chk("mid_rst_in_valid", 32'(in_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 read_done = 1'b1;
        data_out = 16'hEE;
        #6 chk("post_rst_rsp_rd", 32'(rsp_read_valid), 32'd0);
        @(posedge clk);
        #1 read_done = 1'b0;
        #6;
        chk("discarded_rsp_rd", 32'(rsp_read_valid), 32'd0);
        chk("discarded_err", 32'(err_unexpected), 32'd1);
        rst_n = 1'b0;
        #1 chk("err_cleared", 32'(err_unexpected), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = part1_end; k < vecs.size(); k++) begin
            run_vec(k);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
